// File: rtl/reorder_buffer_pkg.sv
// Shared constants and the entry layout for the reorder buffer.
// The allocator and the top level both import this package.
package reorder_buffer_pkg;

    localparam int ROB_SIZE      = 16;
    localparam int ROB_TAG_WIDTH = $clog2(ROB_SIZE);
    localparam int DATA_SIZE     = 64;
    localparam int RD_WIDTH      = 5;

    // One in-flight instruction: allocated (valid), result written (done),
    // its architectural destination, its PC and its result value.
    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [RD_WIDTH-1:0]  rd;
        logic [DATA_SIZE-1:0] pc;
        logic [DATA_SIZE-1:0] value;
    } rob_entry;

    // Tags are ring indices; ROB_SIZE is a power of two, so a plain
    // increment wraps from ROB_SIZE-1 back to 0.
    function automatic logic [ROB_TAG_WIDTH-1:0] next_tag(input logic [ROB_TAG_WIDTH-1:0] t);
        return t + 1'b1;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of the dispatch, result-bus, lookup and commit signals of the
// reorder buffer. The slave modport is the buffer itself; the master
// modport is the surrounding pipeline (dispatch, CDB, register file).
//
// Handshakes: alloc_valid/alloc_ready and commit_valid/commit_ready are
// plain valid/ready pairs. A transfer happens on a rising clk edge where
// both are high; the valid side holds its payload stable until then, and
// neither ready depends combinationally on its own valid.
interface rob_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64
);
    import reorder_buffer_pkg::*;

    logic                alloc_valid;
    logic                alloc_ready;
    logic [RD_WIDTH-1:0] alloc_rd;
    logic [DATA_W-1:0]   alloc_pc;
    logic [TAG_W-1:0]    alloc_tag;

    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_value;

    logic [TAG_W-1:0]    q1_tag;
    logic [TAG_W-1:0]    q2_tag;
    logic                q1_ready;
    logic                q2_ready;
    logic [DATA_W-1:0]   q1_value;
    logic [DATA_W-1:0]   q2_value;

    logic                commit_valid;
    logic                commit_ready;
    logic [RD_WIDTH-1:0] commit_rd;
    logic [DATA_W-1:0]   commit_value;
    logic [DATA_W-1:0]   commit_pc;
    logic [TAG_W-1:0]    commit_tag;

    logic                flush;
    logic [TAG_W:0]      count;

    modport slave (
        input  alloc_valid, alloc_rd, alloc_pc,
        input  cdb_valid, cdb_tag, cdb_value,
        input  q1_tag, q2_tag,
        input  commit_ready, flush,
        output alloc_ready, alloc_tag,
        output q1_ready, q2_ready, q1_value, q2_value,
        output commit_valid, commit_rd, commit_value, commit_pc, commit_tag,
        output count
    );

    modport master (
        output alloc_valid, alloc_rd, alloc_pc,
        output cdb_valid, cdb_tag, cdb_value,
        output q1_tag, q2_tag,
        output commit_ready, flush,
        input  alloc_ready, alloc_tag,
        input  q1_ready, q2_ready, q1_value, q2_value,
        input  commit_valid, commit_rd, commit_value, commit_pc, commit_tag,
        input  count
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation at tail, out-of-order
// completion from the common data bus, in-order retirement from head,
// plus two operand lookups with same-cycle CDB forwarding.
module reorder_buffer #(
    parameter int ROB_SIZE  = reorder_buffer_pkg::ROB_SIZE,
    parameter int DATA_SIZE = reorder_buffer_pkg::DATA_SIZE
) (
    input logic  clk,
    input logic  reset,
    rob_if.slave rob
);
    import reorder_buffer_pkg::*;

    localparam int ROB_TAG_WIDTH = $clog2(ROB_SIZE);
    localparam logic [ROB_TAG_WIDTH:0] FULL_COUNT = (ROB_TAG_WIDTH+1)'(ROB_SIZE);

    rob_entry                 rob_q [ROB_SIZE];
    logic [ROB_TAG_WIDTH-1:0] head_q;
    logic [ROB_TAG_WIDTH-1:0] tail_q;
    logic [ROB_TAG_WIDTH:0]   count_q;

    logic do_alloc;
    logic do_commit;
    logic cdb_hit;
    logic head_ready;

    // Fullness comes from registered count only, so a commit in the same
    // cycle never opens a slot early.
    assign rob.alloc_ready = (count_q != FULL_COUNT);
    assign rob.alloc_tag   = tail_q;
    assign rob.count       = count_q;

    assign head_ready = (count_q != '0) && rob_q[head_q].done;
    assign do_alloc   = rob.alloc_valid && rob.alloc_ready;
    assign do_commit  = head_ready && rob.commit_ready;
    // Results for empty or already-completed slots are stale and dropped.
    assign cdb_hit    = rob.cdb_valid && rob_q[rob.cdb_tag].valid && !rob_q[rob.cdb_tag].done;

    // Head entry presented for retirement; data zeroed when not presented.
    always_comb begin
        rob.commit_valid = head_ready;
        rob.commit_rd    = '0;
        rob.commit_value = '0;
        rob.commit_pc    = '0;
        rob.commit_tag   = '0;
        if (head_ready) begin
            rob.commit_rd    = rob_q[head_q].rd;
            rob.commit_value = rob_q[head_q].value;
            rob.commit_pc    = rob_q[head_q].pc;
            rob.commit_tag   = head_q;
        end
    end

    // Operand lookups: stored result if done, else forward a matching CDB
    // broadcast into a live entry, else not ready with a zero value.
    always_comb begin
        rob.q1_ready = 1'b0;
        rob.q1_value = '0;
        rob.q2_ready = 1'b0;
        rob.q2_value = '0;
        if (rob_q[rob.q1_tag].valid && rob_q[rob.q1_tag].done) begin
            rob.q1_ready = 1'b1;
            rob.q1_value = rob_q[rob.q1_tag].value;
        end else if (rob.cdb_valid && (rob.cdb_tag == rob.q1_tag) && rob_q[rob.q1_tag].valid) begin
            rob.q1_ready = 1'b1;
            rob.q1_value = rob.cdb_value;
        end
        if (rob_q[rob.q2_tag].valid && rob_q[rob.q2_tag].done) begin
            rob.q2_ready = 1'b1;
            rob.q2_value = rob_q[rob.q2_tag].value;
        end else if (rob.cdb_valid && (rob.cdb_tag == rob.q2_tag) && rob_q[rob.q2_tag].valid) begin
            rob.q2_ready = 1'b1;
            rob.q2_value = rob.cdb_value;
        end
    end

    // Entry array and pointers; flush outranks every other update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rob_q[i] <= '0;
            end
        end else if (rob.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rob_q[i].valid <= 1'b0;
                rob_q[i].done  <= 1'b0;
            end
        end else begin
            if (do_alloc) begin
                rob_q[tail_q].valid <= 1'b1;
                rob_q[tail_q].done  <= 1'b0;
                rob_q[tail_q].rd    <= rob.alloc_rd;
                rob_q[tail_q].pc    <= rob.alloc_pc;
                rob_q[tail_q].value <= '0;
                tail_q              <= next_tag(tail_q);
            end
            if (cdb_hit) begin
                rob_q[rob.cdb_tag].done  <= 1'b1;
                rob_q[rob.cdb_tag].value <= rob.cdb_value;
            end
            if (do_commit) begin
                rob_q[head_q].valid <= 1'b0;
                head_q              <= next_tag(head_q);
            end
            if (do_alloc && !do_commit) begin
                count_q <= count_q + 1'b1;
            end else if (!do_alloc && do_commit) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// a random phase, with a scoreboard of allocated entries in commit order.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int TW   = 4;
    localparam int DW   = 64;
    localparam int NE   = 16;
    localparam int SB_W = TW + 5 + DW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rob_if #(.TAG_W(TW), .DATA_W(DW)) rob_bus ();

    reorder_buffer #(.ROB_SIZE(NE), .DATA_SIZE(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rob_bus)
    );

    // ---------------- scoreboard / model ----------------
    int vectors     = 0;
    int miscompares = 0;
    int dut_commits = 0;

    logic [SB_W-1:0] exp_q[$];
    logic            m_valid [NE];
    logic            m_done  [NE];
    logic [DW-1:0]   m_value [NE];
    int              m_head, m_tail, m_count;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b0;
            m_value[i] = '0;
        end
        m_head  = 0;
        m_tail  = 0;
        m_count = 0;
        exp_q.delete();
    endtask

    function automatic logic m_q_ready(input logic [TW-1:0] t);
        return (m_valid[t] && m_done[t]) ||
               (rob_bus.cdb_valid && rob_bus.cdb_tag == t && m_valid[t]);
    endfunction

    function automatic logic [DW-1:0] m_q_value(input logic [TW-1:0] t);
        if (m_valid[t] && m_done[t]) return m_value[t];
        if (rob_bus.cdb_valid && rob_bus.cdb_tag == t && m_valid[t]) return rob_bus.cdb_value;
        return '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rob_bus.alloc_valid  = 1'b0;
        rob_bus.alloc_rd     = '0;
        rob_bus.alloc_pc     = '0;
        rob_bus.cdb_valid    = 1'b0;
        rob_bus.cdb_tag      = '0;
        rob_bus.cdb_value    = '0;
        rob_bus.q1_tag       = '0;
        rob_bus.q2_tag       = '0;
        rob_bus.commit_ready = 1'b0;
        rob_bus.flush        = 1'b0;
    endtask

    task automatic drive_alloc(input logic [4:0] rd, input logic [DW-1:0] pc);
        rob_bus.alloc_valid = 1'b1;
        rob_bus.alloc_rd    = rd;
        rob_bus.alloc_pc    = pc;
    endtask

    task automatic drive_cdb(input logic [TW-1:0] tag, input logic [DW-1:0] val);
        rob_bus.cdb_valid = 1'b1;
        rob_bus.cdb_tag   = tag;
        rob_bus.cdb_value = val;
    endtask

    // Check every output against the model, then advance model and clock.
    task automatic step();
        logic            cv, fire_a, fire_c, hit;
        logic [SB_W-1:0] front;
        #1;
        check("alloc_ready", rob_bus.alloc_ready, m_count != NE);
        check("alloc_tag", rob_bus.alloc_tag, m_tail);
        check("count", rob_bus.count, m_count);
        check("q1_ready", rob_bus.q1_ready, m_q_ready(rob_bus.q1_tag));
        check("q1_value", rob_bus.q1_value, m_q_value(rob_bus.q1_tag));
        check("q2_ready", rob_bus.q2_ready, m_q_ready(rob_bus.q2_tag));
        check("q2_value", rob_bus.q2_value, m_q_value(rob_bus.q2_tag));
        cv = (m_count != 0) && m_done[m_head];
        check("commit_valid", rob_bus.commit_valid, cv);
        if (cv) begin
            front = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("commit_tag", rob_bus.commit_tag, front[SB_W-1 -: TW]);
            check("commit_rd", rob_bus.commit_rd, front[DW+4:DW]);
            check("commit_pc", rob_bus.commit_pc, front[DW-1:0]);
            check("commit_value", rob_bus.commit_value, m_value[m_head]);
        end else begin
            check("idle_commit_rd", rob_bus.commit_rd, '0);
            check("idle_commit_pc", rob_bus.commit_pc, '0);
            check("idle_commit_value", rob_bus.commit_value, '0);
            check("idle_commit_tag", rob_bus.commit_tag, '0);
        end
        if (rob_bus.commit_valid && rob_bus.commit_ready && reset) dut_commits++;
        if (!reset || rob_bus.flush) begin
            model_clear();
        end else begin
            fire_c = cv && rob_bus.commit_ready;
            fire_a = rob_bus.alloc_valid && (m_count != NE);
            hit    = rob_bus.cdb_valid && m_valid[rob_bus.cdb_tag] && !m_done[rob_bus.cdb_tag];
            if (fire_c) begin
                m_valid[m_head] = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_head = (m_head + 1) % NE;
            end
            if (hit) begin
                m_done[rob_bus.cdb_tag]  = 1'b1;
                m_value[rob_bus.cdb_tag] = rob_bus.cdb_value;
            end
            if (fire_a) begin
                m_valid[m_tail] = 1'b1;
                m_done[m_tail]  = 1'b0;
                m_value[m_tail] = '0;
                exp_q.push_back({TW'(m_tail), rob_bus.alloc_rd, rob_bus.alloc_pc});
                m_tail = (m_tail + 1) % NE;
            end
            m_count = m_count + int'(fire_a) - int'(fire_c);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        model_clear();
        // Outputs held at their reset values while reset is low.
        step();
        step();
        reset = 1'b1;
        step();

        // In-order commit despite out-of-order completion.
        rob_bus.commit_ready = 1'b1;
        drive_alloc(5'd5, 64'h1000); step();
        drive_alloc(5'd6, 64'h1004); step();
        drive_alloc(5'd7, 64'h1008); step();
        rob_bus.alloc_valid = 1'b0;
        drive_cdb(4'd2, 64'hC); step();
        drive_cdb(4'd0, 64'hA); step();
        drive_cdb(4'd1, 64'hB); step();
        rob_bus.cdb_valid = 1'b0;
        repeat (5) step();
        check("s_order_commits", dut_commits, 3);

        // Fill to full with retirement stalled, then commit while allocating.
        rob_bus.flush = 1'b1; step();
        rob_bus.flush        = 1'b0;
        rob_bus.commit_ready = 1'b0;
        for (int i = 0; i < NE; i++) begin
            drive_alloc(5'(i), 64'h2000 + 64'(i * 4));
            step();
        end
        rob_bus.alloc_valid = 1'b0;
        for (int i = 0; i < NE; i++) begin
            drive_cdb(4'(i), 64'h100 + 64'(i));
            step();
        end
        rob_bus.cdb_valid = 1'b0;
        check("full_alloc_ready", rob_bus.alloc_ready, 1'b0);
        check("full_count", rob_bus.count, 5'd16);
        rob_bus.commit_ready = 1'b1;
        drive_alloc(5'd9, 64'h3000);
        step();
        rob_bus.commit_ready = 1'b0;
        check("after_commit_ready", rob_bus.alloc_ready, 1'b1);
        check("wrap_alloc_tag", rob_bus.alloc_tag, 4'd0);
        step();
        rob_bus.alloc_valid = 1'b0;
        // Stalled retirement: head entry held, count steady.
        for (int i = 0; i < 3; i++) begin
            check("hold_commit_valid", rob_bus.commit_valid, 1'b1);
            check("hold_commit_tag", rob_bus.commit_tag, 4'd1);
            check("hold_commit_value", rob_bus.commit_value, 64'h101);
            check("hold_count", rob_bus.count, 5'd16);
            step();
        end
        rob_bus.commit_ready = 1'b1;
        drive_cdb(4'd0, 64'h99);
        step();
        rob_bus.cdb_valid = 1'b0;
        repeat (18) step();

        // Same-cycle CDB forwarding to an operand lookup.
        rob_bus.flush = 1'b1; step();
        rob_bus.flush        = 1'b0;
        rob_bus.commit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_alloc(5'(i + 1), 64'h4000 + 64'(i));
            step();
        end
        rob_bus.alloc_valid = 1'b0;
        rob_bus.q1_tag = 4'd3;
        rob_bus.q2_tag = 4'd0;
        drive_cdb(4'd3, 64'h55);
        #1;
        check("fwd_q1_ready", rob_bus.q1_ready, 1'b1);
        check("fwd_q1_value", rob_bus.q1_value, 64'h55);
        check("fwd_q2_ready", rob_bus.q2_ready, 1'b0);
        check("fwd_q2_value", rob_bus.q2_value, '0);
        step();
        rob_bus.cdb_valid = 1'b0;
        #1;
        check("stored_q1_ready", rob_bus.q1_ready, 1'b1);
        check("stored_q1_value", rob_bus.q1_value, 64'h55);

        // Flush beats a simultaneous allocation and CDB write.
        rob_bus.flush = 1'b1;
        drive_alloc(5'd3, 64'h5000);
        drive_cdb(4'd1, 64'h77);
        step();
        idle_inputs();
        check("flush_count", rob_bus.count, '0);
        check("flush_alloc_tag", rob_bus.alloc_tag, '0);
        check("flush_commit_valid", rob_bus.commit_valid, 1'b0);
        step();

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 5; i++) begin
            drive_alloc(5'(i + 10), 64'h6000 + 64'(i));
            step();
        end
        rob_bus.alloc_valid = 1'b0;
        drive_cdb(4'd0, 64'h66);
        step();
        rob_bus.cdb_valid = 1'b0;
        check("pre_reset_count", rob_bus.count, 5'd5);
        check("pre_reset_commit_valid", rob_bus.commit_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_count", rob_bus.count, '0);
        check("async_reset_commit_valid", rob_bus.commit_valid, 1'b0);
        check("async_reset_alloc_ready", rob_bus.alloc_ready, 1'b1);
        model_clear();
        step();
        reset = 1'b1;
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rob_bus.alloc_valid  = ($urandom_range(0, 99) < 60);
            rob_bus.alloc_rd     = 5'($urandom_range(0, 31));
            rob_bus.alloc_pc     = {32'($urandom), 32'($urandom)};
            rob_bus.cdb_valid    = ($urandom_range(0, 99) < 60);
            rob_bus.cdb_tag      = 4'($urandom_range(0, NE - 1));
            rob_bus.cdb_value    = {32'($urandom), 32'($urandom)};
            rob_bus.q1_tag       = 4'($urandom_range(0, NE - 1));
            rob_bus.q2_tag       = 4'($urandom_range(0, NE - 1));
            rob_bus.commit_ready = ($urandom_range(0, 99) < 50);
            rob_bus.flush        = ($urandom_range(0, 99) < 2);
            step();
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
